alu_md: RTL

Parametrised, handshaked successor to the single-cycle RV32 ALU. It executes the twelve base ALU operations with one registered cycle of latency. It adds unsigned multiply, multiply-high, divide and remainder through a shared iterative shift/add-subtract datapath. It sits between the decode/operand stage and writeback, with valid/ready on both sides so a multi-cycle operation can stall the producer.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_core.sv | 66 ++++++
 rtl/alu_md.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the handshaked RV32-style ALU with iterative mul/div:
// op codes, flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SLL   = 4'h1,
        OP_SLT   = 4'h2,
        OP_SLTU  = 4'h3,
        OP_XOR   = 4'h4,
        OP_SRL   = 4'h5,
        OP_OR    = 4'h6,
        OP_AND   = 4'h7,
        OP_SUB   = 4'h8,
        OP_SRA   = 4'h9,
        OP_ADDU  = 4'hA,
        OP_SUBU  = 4'hB,
        OP_MUL   = 4'hC,
        OP_MULHU = 4'hD,
        OP_DIVU  = 4'hE,
        OP_REMU  = 4'hF
    } alu_op_e;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_SF = 2;
    localparam int FLAG_CF = 1;
    localparam int FLAG_OF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Codes 0xC..0xF form the iterative group
    function automatic logic is_iter_op(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op[3] & op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational base-group ALU (codes 0x0..0xB) with flag generation.
// Iterative-group codes produce zero here; the top handles them.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] res_s;
    logic             cf_s;
    logic             of_s;

    // Base operation result plus carry/borrow and signed overflow
    always_comb begin
        sum_s   = {1'b0, lhs} + {1'b0, rhs};
        diff_s  = {1'b0, lhs} - {1'b0, rhs};
        shamt_s = rhs[SHW-1:0];
        res_s   = '0;
        cf_s    = 1'b0;
        of_s    = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                cf_s  = sum_s[WIDTH];
                of_s  = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum_s[WIDTH-1] != lhs[WIDTH-1]);
            end
            OP_ADDU: begin
                res_s = sum_s[WIDTH-1:0];
                cf_s  = sum_s[WIDTH];
            end
            OP_SUB: begin
                res_s = diff_s[WIDTH-1:0];
                cf_s  = diff_s[WIDTH];
                of_s  = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (diff_s[WIDTH-1] != lhs[WIDTH-1]);
            end
            OP_SUBU: begin
                res_s = diff_s[WIDTH-1:0];
                cf_s  = diff_s[WIDTH];
            end
            OP_SLL:  res_s = lhs << shamt_s;
            OP_SRL:  res_s = lhs >> shamt_s;
            OP_SRA:  res_s = $unsigned($signed(lhs) >>> shamt_s);
            OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(lhs) < $signed(rhs))};
            OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (lhs < rhs)};
            OP_XOR:  res_s = lhs ^ rhs;
            OP_OR:   res_s = lhs | rhs;
            OP_AND:  res_s = lhs & rhs;
            default: res_s = '0;
        endcase
    end

    assign res   = res_s;
    assign flags = {(res_s == '0), res_s[WIDTH-1], cf_s, of_s};

endmodule

// File: rtl/alu_md.sv
// Handshaked ALU: single-cycle base ops via alu_core, plus a shared iterative
// shift/add-subtract datapath for mul, mulhu, divu and remu.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    alu_state_e         state_r;
    alu_state_e         state_nx;
    logic [SHW-1:0]     cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic               div_r;
    logic               hi_sel_r;
    logic [WIDTH-1:0]   res_r;
    logic [3:0]         flags_r;
    logic               out_valid_r;

    logic               accept_s;
    logic               zero_div_s;
    logic               start_iter_s;
    logic               load_iter_s;
    logic               load_base_s;
    logic               step_en_s;
    logic               finish_s;
    logic               drop_s;

    logic [WIDTH-1:0]   core_res_s;
    logic [3:0]         core_flags_s;
    logic [WIDTH-1:0]   short_res_s;
    logic [3:0]         short_flags_s;

    logic [WIDTH:0]     add_hi_s;
    logic [2*WIDTH:0]   shl_s;
    logic [WIDTH:0]     trial_s;
    logic [2*WIDTH-1:0] step_s;
    logic [WIDTH-1:0]   fin_res_s;

    assign in_ready     = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    assign accept_s     = in_valid & in_ready;
    assign zero_div_s   = is_div_op(op) & (rhs == '0);
    assign start_iter_s = is_iter_op(op) & ~zero_div_s;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op    (op),
        .lhs   (lhs),
        .rhs   (rhs),
        .res   (core_res_s),
        .flags (core_flags_s)
    );

    // Single-cycle result: base op, or divide-by-zero short circuit
    always_comb begin
        if (zero_div_s) begin
            short_res_s   = op[0] ? lhs : '1;
            short_flags_s = {(short_res_s == '0), short_res_s[WIDTH-1], 2'b00};
        end else begin
            short_res_s   = core_res_s;
            short_flags_s = core_flags_s;
        end
    end

    // One iteration: radix-2 shift-add multiply or restoring divide step.
    // The shifted partial remainder needs WIDTH+1 bits before the trial subtract.
    always_comb begin
        add_hi_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : '0);
        shl_s    = {acc_r, 1'b0};
        trial_s  = shl_s[2*WIDTH:WIDTH] - {1'b0, opnd_r};
        if (div_r) begin
            if (!trial_s[WIDTH]) begin
                step_s = {trial_s[WIDTH-1:0], shl_s[WIDTH-1:1], 1'b1};
            end else begin
                step_s = shl_s[2*WIDTH-1:0];
            end
        end else begin
            step_s = {add_hi_s, acc_r[WIDTH-1:1]};
        end
        fin_res_s = hi_sel_r ? step_s[2*WIDTH-1:WIDTH] : step_s[WIDTH-1:0];
    end

    // Next-state and datapath control
    always_comb begin
        state_nx    = state_r;
        load_iter_s = 1'b0;
        load_base_s = 1'b0;
        step_en_s   = 1'b0;
        finish_s    = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (start_iter_s) begin
                        state_nx    = ST_EXEC;
                        load_iter_s = 1'b1;
                    end else begin
                        state_nx    = ST_DONE;
                        load_base_s = 1'b1;
                    end
                end else if ((state_r == ST_DONE) && out_ready) begin
                    state_nx = ST_IDLE;
                    drop_s   = 1'b1;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_EXEC: begin
                if (kill) begin
                    state_nx = ST_IDLE;
                end else if (cnt_r == LAST_ITER) begin
                    state_nx = ST_DONE;
                    finish_s = 1'b1;
                end else begin
                    step_en_s = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Iterative datapath, counter and registered result/flags/valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            acc_r       <= '0;
            opnd_r      <= '0;
            div_r       <= 1'b0;
            hi_sel_r    <= 1'b0;
            res_r       <= '0;
            flags_r     <= 4'b0000;
            out_valid_r <= 1'b0;
        end else if (load_iter_s) begin
            acc_r       <= {{WIDTH{1'b0}}, (is_div_op(op) ? lhs : rhs)};
            opnd_r      <= is_div_op(op) ? rhs : lhs;
            div_r       <= op[1];
            hi_sel_r    <= op[0];
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (step_en_s) begin
            acc_r <= step_s;
            cnt_r <= cnt_r + SHW'(1);
        end else if (finish_s) begin
            acc_r       <= step_s;
            res_r       <= fin_res_s;
            flags_r     <= {(fin_res_s == '0), fin_res_s[WIDTH-1], 2'b00};
            out_valid_r <= 1'b1;
        end else if (load_base_s) begin
            res_r       <= short_res_s;
            flags_r     <= short_flags_s;
            out_valid_r <= 1'b1;
        end else if (drop_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign res       = res_r;
    assign flags     = flags_r;

endmodule
